// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: RAM request/response, redirect and decode handshake.
// slave = fetch_queue side, master = RAMs/decode side.
interface fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int OW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] fetch_adr;
    logic            fetch_req;
    logic [XLEN-1:0] bios_instr;
    logic [XLEN-1:0] imem_instr;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            deq_ready;
    logic            out_valid;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc_plus4;
    logic [OW-1:0]   occupancy;
    logic            misalign_err;
    logic [31:0]     bubble_cnt;

    modport slave (
        output fetch_adr, fetch_req,
        input  bios_instr, imem_instr,
        input  redirect_valid, redirect_pc, deq_ready,
        output out_valid, out_instr, out_pc_plus4,
        output occupancy, misalign_err, bubble_cnt
    );

    modport master (
        input  fetch_adr, fetch_req,
        output bios_instr, imem_instr,
        output redirect_valid, redirect_pc, deq_ready,
        input  out_valid, out_instr, out_pc_plus4,
        input  occupancy, misalign_err, bubble_cnt
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, reads BIOS/IMEM (1-cycle RAMs),
// buffers responses in a DEPTH-entry FIFO drained by decode.
// Ports: clk, rst (sync, active-high), bus (fetch_queue_if.slave):
//   fetch_adr/fetch_req out, bios_instr/imem_instr in, redirect_valid/pc in,
//   deq_ready in, out_valid/out_instr/out_pc_plus4 out, occupancy out,
//   misalign_err (sticky) out, bubble_cnt (saturating) out.
module fetch_queue #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h4000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input logic          clk,
    input logic          rst,
    fetch_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);
    localparam int CW = OW + 2;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_pc;
    logic            r_inflight;
    logic [XLEN-1:0] r_instr_mem [DEPTH];
    logic [XLEN-1:0] r_pc4_mem   [DEPTH];
    logic [AW-1:0]   r_rptr;
    logic [AW-1:0]   r_wptr;
    logic [OW-1:0]   r_occ;
    logic            r_mis;
    logic [31:0]     r_bub;

    logic            w_enq;
    logic            w_deq;
    logic            w_req;
    logic [CW-1:0]   w_credit;
    logic [XLEN-1:0] w_resp;

    assign w_enq = r_inflight && !bus.redirect_valid;
    assign w_deq = (r_occ != '0) && bus.deq_ready;

    // Slots committed: stored + in flight + landing now - leaving now.
    assign w_credit = CW'(r_occ) + CW'(r_inflight)
                    + CW'(w_enq) - CW'(w_deq);

    assign w_req = !rst && !bus.redirect_valid
                && (w_credit < CW'(DEPTH));

    // Region of the request that is returning this cycle.
    always_comb begin
        w_resp = NOP_INSTR;
        unique case (r_req_pc[31:28])
            4'h4:       w_resp = bus.bios_instr;
            4'h1, 4'h2: w_resp = bus.imem_instr;
            default:    w_resp = NOP_INSTR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_inflight <= 1'b0;
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_occ      <= '0;
            r_mis      <= 1'b0;
            r_bub      <= '0;
        end else begin
            if (r_occ == '0 && r_bub != 32'hFFFF_FFFF)
                r_bub <= r_bub + 32'd1;
            if (bus.redirect_valid) begin
                // Redirect beats any enqueue/dequeue this cycle.
                r_rptr     <= '0;
                r_wptr     <= '0;
                r_occ      <= '0;
                r_inflight <= 1'b0;
                r_pc       <= {bus.redirect_pc[XLEN-1:2], 2'b00};
                if (bus.redirect_pc[1:0] != 2'b00)
                    r_mis <= 1'b1;
            end else begin
                r_inflight <= w_req;
                if (w_req) begin
                    r_pc     <= r_pc + XLEN'(4);
                    r_req_pc <= r_pc;
                end
                if (w_enq)
                    r_wptr <= r_wptr + AW'(1);
                if (w_deq)
                    r_rptr <= r_rptr + AW'(1);
                r_occ <= r_occ + OW'(w_enq) - OW'(w_deq);
            end
        end
    end

    // Storage needs no reset; r_occ qualifies every read.
    always_ff @(posedge clk) begin
        if (!rst && w_enq) begin
            r_instr_mem[r_wptr] <= w_resp;
            r_pc4_mem[r_wptr]   <= r_req_pc + XLEN'(4);
        end
    end

    assign bus.fetch_adr    = r_pc;
    assign bus.fetch_req    = w_req;
    assign bus.out_valid    = (r_occ != '0);
    assign bus.out_instr    = r_instr_mem[r_rptr];
    assign bus.out_pc_plus4 = r_pc4_mem[r_rptr];
    assign bus.occupancy    = r_occ;
    assign bus.misalign_err = r_mis;
    assign bus.bubble_cnt   = r_bub;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed table, corner sequences, random traffic
// checked against a queue-based reference model.
module tb_fetch_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h4000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [31:0] bios_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hB105_B105;
    endfunction

    function automatic logic [31:0] imem_fn(input logic [31:0] a);
        return (a * 32'h85EB_CA6B) ^ 32'h1AE3_0000;
    endfunction

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        logic [3:0] reg_n;
        reg_n = a[31:28];
        if (reg_n == 4'h4) return bios_fn(a);
        if (reg_n == 4'h1 || reg_n == 4'h2) return imem_fn(a);
        return NOP;
    endfunction

    // Synchronous RAMs: address registered, data the next cycle.
    logic [31:0] ram_a;
    always @(posedge clk) ram_a <= bus.fetch_adr;
    assign bus.bios_instr = bios_fn(ram_a);
    assign bus.imem_instr = imem_fn(ram_a);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: queue of delivered entries plus one pending fetch.
    logic [31:0] mq_i[$];
    logic [31:0] mq_p[$];
    logic [31:0] m_pc;
    logic [31:0] m_ipc;
    logic [31:0] m_bub;
    bit m_inf;
    bit m_mis;
    bit m_live = 1'b0;

    bit          c_r;
    bit          c_rv;
    logic [31:0] c_rpc;
    bit          c_dr;

    task automatic drive(input bit r, input bit rv,
                         input logic [31:0] rpc, input bit dr);
        @(negedge clk);
        rst                = r;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.deq_ready      = dr;
        c_r = r; c_rv = rv; c_rpc = rpc; c_dr = dr;
        #1;
    endtask

    task automatic tick();
        bit deq;
        bit req;
        int cred;
        int n;
        n    = mq_i.size();
        deq  = (n != 0) && c_dr;
        cred = n + int'(m_inf) + int'(m_inf && !c_rv) - int'(deq);
        req  = !c_r && !c_rv && (cred < DEPTH);
        if (m_live) begin
            chk("m_valid", 32'(bus.out_valid), 32'(n != 0));
            chk("m_occ", 32'(bus.occupancy), 32'(n));
            chk("m_req", 32'(bus.fetch_req), 32'(req));
            chk("m_adr", bus.fetch_adr, m_pc);
            chk("m_mis", 32'(bus.misalign_err), 32'(m_mis));
            chk("m_bub", bus.bubble_cnt, m_bub);
            if (n != 0) begin
                chk("m_instr", bus.out_instr, mq_i[0]);
                chk("m_pc4", bus.out_pc_plus4, mq_p[0]);
            end
        end
        if (c_r) begin
            mq_i.delete(); mq_p.delete();
            m_pc = RST_PC; m_inf = 0; m_mis = 0; m_bub = 0;
            m_live = 1'b1;
        end else begin
            if (n == 0 && m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
            if (c_rv) begin
                mq_i.delete(); mq_p.delete();
                m_inf = 0;
                m_pc  = {c_rpc[31:2], 2'b00};
                if (c_rpc[1:0] != 2'b00) m_mis = 1;
            end else begin
                if (deq) begin
                    void'(mq_i.pop_front());
                    void'(mq_p.pop_front());
                end
                if (m_inf) begin
                    mq_i.push_back(mem_fn(m_ipc));
                    mq_p.push_back(m_ipc + 4);
                end
                m_inf = req;
                if (req) begin
                    m_ipc = m_pc;
                    m_pc  = m_pc + 4;
                end
            end
        end
    endtask

    task automatic cyc(input bit r, input bit rv,
                       input logic [31:0] rpc, input bit dr);
        drive(r, rv, rpc, dr);
        tick();
    endtask

    typedef struct {
        bit          r;
        bit          dr;
        bit          ev;
        int          eocc;
        bit          ereq;
        logic [31:0] eadr;
        logic [31:0] epc4;
        logic [31:0] ebub;
    } vec_t;

    vec_t tv[13];

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.deq_ready      = 1'b0;

        tv[0]  = '{1, 0, 0, 0, 0, 32'h4000_0000, 32'h0, 0};
        tv[1]  = '{0, 0, 0, 0, 1, 32'h4000_0000, 32'h0, 0};
        tv[2]  = '{0, 0, 0, 0, 1, 32'h4000_0004, 32'h0, 1};
        tv[3]  = '{0, 0, 1, 1, 1, 32'h4000_0008, 32'h4000_0004, 2};
        tv[4]  = '{0, 0, 1, 2, 0, 32'h4000_000C, 32'h4000_0004, 2};
        tv[5]  = '{0, 0, 1, 3, 1, 32'h4000_000C, 32'h4000_0004, 2};
        tv[6]  = '{0, 0, 1, 3, 0, 32'h4000_0010, 32'h4000_0004, 2};
        tv[7]  = '{0, 0, 1, 4, 0, 32'h4000_0010, 32'h4000_0004, 2};
        tv[8]  = '{0, 1, 1, 4, 1, 32'h4000_0010, 32'h4000_0004, 2};
        tv[9]  = '{0, 1, 1, 3, 0, 32'h4000_0014, 32'h4000_0008, 2};
        tv[10] = '{0, 1, 1, 3, 1, 32'h4000_0014, 32'h4000_000C, 2};
        tv[11] = '{0, 1, 1, 2, 1, 32'h4000_0018, 32'h4000_0010, 2};
        tv[12] = '{0, 1, 1, 2, 1, 32'h4000_001C, 32'h4000_0014, 2};

        cyc(1, 0, 0, 0);

        // Startup, fill to full, then drain in order.
        for (int i = 0; i < 13; i++) begin
            drive(tv[i].r, 0, 0, tv[i].dr);
            chk($sformatf("t%0d_valid", i), 32'(bus.out_valid), 32'(tv[i].ev));
            chk($sformatf("t%0d_occ", i), 32'(bus.occupancy), 32'(tv[i].eocc));
            chk($sformatf("t%0d_req", i), 32'(bus.fetch_req), 32'(tv[i].ereq));
            chk($sformatf("t%0d_adr", i), bus.fetch_adr, tv[i].eadr);
            chk($sformatf("t%0d_bub", i), bus.bubble_cnt, tv[i].ebub);
            if (tv[i].ev) begin
                chk($sformatf("t%0d_pc4", i), bus.out_pc_plus4, tv[i].epc4);
                chk($sformatf("t%0d_ins", i), bus.out_instr,
                    bios_fn(tv[i].epc4 - 4));
            end
            tick();
        end

        // Redirect with three entries buffered.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        drive(0, 1, 32'h1000_0100, 0);
        chk("rd_pre_occ", 32'(bus.occupancy), 3);
        tick();
        drive(0, 0, 0, 0);
        chk("rd_occ0", 32'(bus.occupancy), 0);
        chk("rd_adr", bus.fetch_adr, 32'h1000_0100);
        chk("rd_req", 32'(bus.fetch_req), 1);
        tick();
        drive(0, 0, 0, 0);
        chk("rd_n2_valid", 32'(bus.out_valid), 0);
        tick();
        drive(0, 0, 0, 1);
        chk("rd_n3_valid", 32'(bus.out_valid), 1);
        chk("rd_n3_ins", bus.out_instr, imem_fn(32'h1000_0100));
        chk("rd_n3_pc4", bus.out_pc_plus4, 32'h1000_0104);
        tick();
        drive(0, 0, 0, 1);
        chk("rd_n4_pc4", bus.out_pc_plus4, 32'h1000_0108);
        chk("rd_mis0", 32'(bus.misalign_err), 0);
        tick();

        // Misaligned target: aligned fetch, sticky flag.
        cyc(0, 1, 32'h1000_0102, 1);
        drive(0, 0, 0, 1);
        chk("mis_set", 32'(bus.misalign_err), 1);
        chk("mis_adr", bus.fetch_adr, 32'h1000_0100);
        tick();
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        chk("mis_sticky", 32'(bus.misalign_err), 1);
        tick();

        // Unmapped region returns NOP.
        cyc(0, 1, 32'h3000_0000, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        chk("nop_valid", 32'(bus.out_valid), 1);
        chk("nop_ins", bus.out_instr, NOP);
        chk("nop_pc4", bus.out_pc_plus4, 32'h3000_0004);
        tick();

        // Back-to-back redirects: only the second stream survives.
        cyc(0, 1, 32'h2000_0000, 1);
        drive(0, 1, 32'h4000_0040, 1);
        chk("b2b_adrA", bus.fetch_adr, 32'h2000_0000);
        tick();
        drive(0, 0, 0, 1);
        chk("b2b_adrB", bus.fetch_adr, 32'h4000_0040);
        chk("b2b_v1", 32'(bus.out_valid), 0);
        tick();
        drive(0, 0, 0, 1);
        chk("b2b_v2", 32'(bus.out_valid), 0);
        tick();
        drive(0, 0, 0, 1);
        chk("b2b_v3", 32'(bus.out_valid), 1);
        chk("b2b_pc4", bus.out_pc_plus4, 32'h4000_0044);
        chk("b2b_ins", bus.out_instr, bios_fn(32'h4000_0040));
        tick();

        // Reset while full.
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        chk("rf_full", 32'(bus.occupancy), DEPTH);
        tick();
        drive(0, 0, 0, 0);
        chk("rf_occ", 32'(bus.occupancy), 0);
        chk("rf_valid", 32'(bus.out_valid), 0);
        chk("rf_bub", bus.bubble_cnt, 0);
        chk("rf_adr", bus.fetch_adr, RST_PC);
        chk("rf_mis", 32'(bus.misalign_err), 0);
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] base;
            logic [31:0] tgt;
            bit r, rv, dr;
            int k;
            k = int'($urandom_range(0, 4));
            case (k)
                0: base = 32'h4000_0000;
                1: base = 32'h1000_0000;
                2: base = 32'h2000_0000;
                3: base = 32'h3000_0000;
                default: base = 32'h5000_0000;
            endcase
            tgt = base | ($urandom & 32'h0000_0FFC);
            if ($urandom_range(0, 15) == 0) tgt[1:0] = 2'($urandom);
            r  = ($urandom_range(0, 149) == 0);
            rv = ($urandom_range(0, 7) == 0);
            dr = ((i / 40) % 3 == 0) ? ($urandom_range(0, 5) == 0)
                                     : ($urandom_range(0, 3) != 0);
            cyc(r, rv, tgt, dr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
